cordic_sincos_seq: RTL

Request/response sequencer around the iterative `cordic` rotation core.
- Accepts one full-circle angle per transaction on a valid/ready input.
- Folds the angle into the core's convergence range and loads x0/y0/z0.
- Pulses the core's start, waits for its done tick, then applies quadrant sign correction.
- Presents cos/sin on a valid/ready output.

It sits directly upstream and downstream of `cordic`, between the core and the rest of the signal path.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/quadrant_fold.sv | 24 ++
 rtl/cordic_sincos_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared constants and FSM state type for the cordic sin/cos sequencer
package cordic_pkg;

  // Data width of angles, core operands and results (Q3.12)
  localparam int DATA_W = 16;

  localparam logic signed [DATA_W-1:0] PI_Q          = 16'sd12868;
  localparam logic signed [DATA_W-1:0] HALF_PI_Q     = 16'sd6434;
  localparam logic signed [DATA_W-1:0] NEG_HALF_PI_Q = -16'sd6434;
  localparam logic signed [DATA_W-1:0] K_Q           = 16'sd2487;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/quadrant_fold.sv
// rtl/quadrant_fold.sv - folds a full-circle angle into the core's +-pi/2 convergence range
module quadrant_fold
  import cordic_pkg::*;
(
  input  logic [DATA_W-1:0] angle_i,
  output logic [DATA_W-1:0] z0_o,
  output logic              neg_o
);

  // Shift by pi when outside +-pi/2; the sign flip is undone on the results later.
  // Exactly +-pi/2 stays unfolded since the core converges there.
  always_comb begin
    z0_o  = angle_i;
    neg_o = 1'b0;
    if ($signed(angle_i) > HALF_PI_Q) begin
      z0_o  = angle_i - PI_Q;
      neg_o = 1'b1;
    end else if ($signed(angle_i) < NEG_HALF_PI_Q) begin
      z0_o  = angle_i + PI_Q;
      neg_o = 1'b1;
    end
  end

endmodule

// File: rtl/cordic_sincos_seq.sv
// rtl/cordic_sincos_seq.sv - request/response sequencer around the iterative cordic core
// Optional build macro: CORDIC_SEQ_TIMEOUT_EN (WAIT watchdog; expiry yields cos=sin=0, err_o=1)
module cordic_sincos_seq
  import cordic_pkg::*;
#(
  parameter int Width         = 16,
  parameter int TimeoutCycles = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] angle_i,
  output logic             start_cordic_o,
  output logic [Width-1:0] x0_o,
  output logic [Width-1:0] y0_o,
  output logic [Width-1:0] z0_o,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic             done_tick_cordic_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] cos_o,
  output logic [Width-1:0] sin_o,
  output logic             err_o
);

  // Package constants are Q3.12 in 16 bits, so no other width can work
  if (Width != DATA_W) begin : g_bad_width
    $error("cordic_sincos_seq: Width must be 16");
  end
  if (TimeoutCycles < 20 || TimeoutCycles > 127) begin : g_bad_timeout
    $error("cordic_sincos_seq: TimeoutCycles must be within 20..127");
  end

  localparam logic [Width-1:0] MostNeg = {1'b1, {(Width-1){1'b0}}};
  localparam logic [Width-1:0] MostPos = {1'b0, {(Width-1){1'b1}}};

  seq_state_e       state_q;
  logic             in_ready_q;
  logic             start_q;
  logic             out_valid_q;
  logic             neg_q;
  logic [Width-1:0] x0_q, y0_q, z0_q;
  logic [Width-1:0] cos_q, sin_q;
  logic [Width-1:0] cos_d, sin_d;
  logic [Width-1:0] fold_z;
  logic             fold_neg;

`ifdef CORDIC_SEQ_TIMEOUT_EN
  localparam logic [6:0] CntLast = 7'(TimeoutCycles - 1);
  logic [6:0] wait_cnt_q;
  logic       err_q;
`endif

  quadrant_fold u_fold (
    .angle_i (angle_i),
    .z0_o    (fold_z),
    .neg_o   (fold_neg)
  );

  // Undo the fold on the core results; negating the most negative code saturates
  always_comb begin
    cos_d = xn_i;
    sin_d = yn_i;
    if (neg_q) begin
      cos_d = (xn_i == MostNeg) ? MostPos : -xn_i;
      sin_d = (yn_i == MostNeg) ? MostPos : -yn_i;
    end
  end

  // Transaction FSM with all outputs registered; one request in flight at a time
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      z0_q        <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
`ifdef CORDIC_SEQ_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            x0_q       <= K_Q;
            y0_q       <= '0;
            z0_q       <= fold_z;
            neg_q      <= fold_neg;
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          start_q <= 1'b0;
          state_q <= S_WAIT;
`ifdef CORDIC_SEQ_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          if (done_tick_cordic_i) begin
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
`ifdef CORDIC_SEQ_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (wait_cnt_q == CntLast) begin
            cos_q       <= '0;
            sin_q       <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            wait_cnt_q  <= wait_cnt_q + 7'd1;
`endif
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign start_cordic_o = start_q;
  assign x0_o           = x0_q;
  assign y0_o           = y0_q;
  assign z0_o           = z0_q;
  assign out_valid_o    = out_valid_q;
  assign cos_o          = cos_q;
  assign sin_o          = sin_q;
`ifdef CORDIC_SEQ_TIMEOUT_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif

endmodule
